// File: rtl/sysctrl_wb_multi.sv
// sysctrl_wb_multi: Wishbone system-control slave with clock/trap/IRQ
// routing bits, a maskable edge-triggered IRQ status bank and an ID word.
//
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low)     clock and reset
//   wb_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i      Wishbone request
//   wb_ack_o, wb_dat_o                         Wishbone response
//   irq_ext_i [N_IRQ]                          asynchronous interrupt lines
//   clk_out_dest [N_CLK], trap_out_dest        routing enables
//   irq_src_sel [N_IRQ]                        1 = take IRQ from pin
//   irq_o                                      |(IRQ_STAT & IRQ_MASK)
`timescale 1ns/1ps
module sysctrl_wb_multi #(
    parameter logic [31:0] BASE_ADR = 32'h2F00_0000,
    parameter int unsigned N_CLK    = 2,
    parameter int unsigned N_IRQ    = 2,
    parameter logic [31:0] ID_VALUE = 32'h5C71_0002
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic             wb_ack_o,
    output logic [31:0]      wb_dat_o,
    input  logic [N_IRQ-1:0] irq_ext_i,
    output logic [N_CLK-1:0] clk_out_dest,
    output logic             trap_out_dest,
    output logic [N_IRQ-1:0] irq_src_sel,
    output logic             irq_o
);

    logic             sel;
    logic             acc;
    logic             wr;
    logic [5:0]       widx;
    logic [31:0]      bmask;
    logic [31:0]      rdata;
    logic [N_CLK-1:0] clk_q;
    logic             trap_q;
    logic [N_IRQ-1:0] src_q;
    logic [N_IRQ-1:0] stat_q;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;
    logic [N_IRQ-1:0] sync3;
    logic [N_IRQ-1:0] irq_set;
    logic [N_IRQ-1:0] irq_clr;
    logic             unused_ok;

    assign sel   = wb_stb_i & wb_cyc_i
                 & (wb_adr_i[31:8] == BASE_ADR[31:8]);
    // An access commits only on the edge that raises ack, so a held
    // strobe yields one access per ack pulse.
    assign acc   = sel & ~wb_ack_o;
    assign wr    = acc & wb_we_i;
    assign widx  = wb_adr_i[7:2];
    assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                    {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // Rising edge after the 2-flop synchroniser, gated by source select.
    assign irq_set = sync2 & ~sync3 & src_q;
    assign irq_clr = (wr && widx == 6'h03)
                   ? (wb_dat_i[N_IRQ-1:0] & bmask[N_IRQ-1:0]) : '0;

    assign unused_ok = &{1'b0, wb_adr_i[1:0], wb_dat_i, bmask};

    always_comb begin
        rdata = '0;
        case (widx)
            6'h00:   rdata = 32'(clk_q);
            6'h01:   rdata = 32'(trap_q);
            6'h02:   rdata = 32'(src_q);
            6'h03:   rdata = 32'(stat_q);
            6'h04:   rdata = 32'(mask_q);
            6'h05:   rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= (acc && !wb_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            clk_q  <= '0;
            trap_q <= 1'b0;
            src_q  <= '0;
            mask_q <= '0;
        end else if (wr) begin
            case (widx)
                6'h00: clk_q <= (clk_q & ~bmask[N_CLK-1:0])
                              | (wb_dat_i[N_CLK-1:0] & bmask[N_CLK-1:0]);
                6'h01: if (wb_sel_i[0]) trap_q <= wb_dat_i[0];
                6'h02: src_q <= (src_q & ~bmask[N_IRQ-1:0])
                              | (wb_dat_i[N_IRQ-1:0] & bmask[N_IRQ-1:0]);
                6'h04: mask_q <= (mask_q & ~bmask[N_IRQ-1:0])
                               | (wb_dat_i[N_IRQ-1:0] & bmask[N_IRQ-1:0]);
                default: ;
            endcase
        end
    end

    // Set has priority over a same-cycle write-1-to-clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            stat_q <= '0;
        end else begin
            sync1  <= irq_ext_i;
            sync2  <= sync1;
            sync3  <= sync2;
            stat_q <= (stat_q & ~irq_clr) | irq_set;
        end
    end

    assign clk_out_dest  = clk_q;
    assign trap_out_dest = trap_q;
    assign irq_src_sel   = src_q;
    assign irq_o         = |(stat_q & mask_q);

endmodule

// File: tb/tb_sysctrl_wb_multi.sv
// tb_sysctrl_wb_multi: scoreboard bench for sysctrl_wb_multi with a
// register-level reference model and randomized bus/IRQ traffic.
`timescale 1ns/1ps
module tb_sysctrl_wb_multi;

    localparam logic [31:0] BASE = 32'h2F00_0000;
    localparam logic [31:0] IDV  = 32'h5C71_0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [1:0]  irq_ext = 2'b00;
    logic        ack;
    logic [31:0] dat_o;
    logic [1:0]  clk_out;
    logic        trap;
    logic [1:0]  src;
    logic        irq;

    always #5 clk = ~clk;

    sysctrl_wb_multi #(
        .BASE_ADR (BASE),
        .N_CLK    (2),
        .N_IRQ    (2),
        .ID_VALUE (IDV)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wb_stb_i      (stb),
        .wb_cyc_i      (cyc),
        .wb_we_i       (we),
        .wb_sel_i      (sel),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat),
        .wb_ack_o      (ack),
        .wb_dat_o      (dat_o),
        .irq_ext_i     (irq_ext),
        .clk_out_dest  (clk_out),
        .trap_out_dest (trap),
        .irq_src_sel   (src),
        .irq_o         (irq)
    );

    typedef struct {
        bit          rd;
        logic [31:0] d;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   fails = 0;

    logic [1:0] m_clk, m_src, m_stat, m_mask;
    logic       m_trap;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic reset_model();
        m_clk = 0; m_src = 0; m_stat = 0; m_mask = 0; m_trap = 0;
    endtask

    function automatic logic [31:0] mread(logic [31:0] a);
        case (a[7:2])
            6'd0:    return {30'b0, m_clk};
            6'd1:    return {31'b0, m_trap};
            6'd2:    return {30'b0, m_src};
            6'd3:    return {30'b0, m_stat};
            6'd4:    return {30'b0, m_mask};
            6'd5:    return IDV;
            default: return 32'h0;
        endcase
    endfunction

    // All implemented fields live in byte 0.
    task automatic mwrite(logic [31:0] a, logic [3:0] s, logic [31:0] d);
        if (!s[0]) return;
        case (a[7:2])
            6'd0: m_clk  = d[1:0];
            6'd1: m_trap = d[0];
            6'd2: m_src  = d[1:0];
            6'd3: m_stat = m_stat & ~d[1:0];
            6'd4: m_mask = d[1:0];
            default: ;
        endcase
    endtask

    task automatic check_outs(string nm);
        chk({nm, " clk_out"}, 32'(clk_out), 32'(m_clk));
        chk({nm, " trap"}, 32'(trap), 32'(m_trap));
        chk({nm, " src"}, 32'(src), 32'(m_src));
        chk({nm, " irq_o"}, 32'(irq), 32'(|(m_stat & m_mask)));
    endtask

    // race: status bits that an edge sets on the very commit edge.
    task automatic bus(logic [31:0] a, bit w, logic [3:0] s,
                       logic [31:0] d, string nm,
                       logic [1:0] race = 2'b00);
        bit inwin;
        bit got;
        int lat;
        exp_t e;
        inwin = (a[31:8] == BASE[31:8]);
        got = 0;
        lat = 0;
        if (inwin) begin
            e.rd = !w;
            e.d  = mread(a);
            e.nm = nm;
            q.push_back(e);
        end
        adr = a; we = w; sel = s; dat = d; stb = 1; cyc = 1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1;
                lat = i;
                break;
            end
        end
        stb = 0; cyc = 0; we = 0;
        if (inwin) begin
            chk({nm, " ack"}, 32'(got), 32'd1);
            if (got) chk({nm, " lat"}, lat, 1);
            if (w) mwrite(a, s, d);
            m_stat = m_stat | race;
        end else begin
            chk({nm, " noack"}, 32'(got), 32'd0);
        end
        @(posedge clk); #1;
        chk({nm, " ackdrop"}, 32'(ack), 32'd0);
        check_outs(nm);
    endtask

    task automatic pulse(logic [1:0] m, string nm);
        irq_ext = irq_ext | m;
        repeat (2) @(posedge clk);
        #1;
        irq_ext = irq_ext & ~m;
        repeat (4) @(posedge clk);
        #1;
        m_stat = m_stat | (m & m_src);
        check_outs(nm);
    endtask

    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                me = q.pop_front();
                if (me.rd) chk({me.nm, " rdata"}, dat_o, me.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst dat", dat_o, 32'd0);
        check_outs("rst");
        rst_n = 1;
        @(posedge clk); #1;

        bus(BASE + 32'h00, 1, 4'hF, 32'h3, "pre_clk");
        bus(BASE + 32'h04, 1, 4'hF, 32'h1, "pre_trap");
        bus(BASE + 32'h08, 1, 4'hF, 32'h3, "pre_src");
        bus(BASE + 32'h10, 1, 4'hF, 32'h3, "pre_mask");
        pulse(2'b01, "pre_irq");

        adr = BASE; we = 1; sel = 4'hF; dat = 32'h0;
        stb = 1; cyc = 1;
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        chk("abort ack", 32'(ack), 32'd0);
        chk("abort dat", dat_o, 32'd0);
        check_outs("abort");
        stb = 0; cyc = 0; we = 0;
        rst_n = 1;
        @(posedge clk); #1;

        bus(BASE + 32'h00, 0, 4'hF, 0, "rd_clk0");
        bus(BASE + 32'h04, 0, 4'hF, 0, "rd_trap0");
        bus(BASE + 32'h08, 0, 4'hF, 0, "rd_src0");
        bus(BASE + 32'h0C, 0, 4'hF, 0, "rd_stat0");
        bus(BASE + 32'h10, 0, 4'hF, 0, "rd_mask0");
        bus(BASE + 32'h14, 0, 4'hF, 0, "rd_id");

        bus(BASE, 1, 4'h0, 32'hFFFF_FFFF, "wr_sel0");
        bus(BASE, 0, 4'hF, 0, "rd_sel0");
        bus(BASE, 1, 4'hE, 32'hFFFF_FFFF, "wr_selE");
        bus(BASE, 0, 4'hF, 0, "rd_selE");
        bus(BASE, 1, 4'h1, 32'hFFFF_FFFF, "wr_sel1");
        bus(BASE, 0, 4'hF, 0, "rd_sel1");
        chk("sel1 clk_out", 32'(clk_out), 32'h3);
        bus(BASE + 32'h20, 1, 4'hF, 32'hFFFF_FFFF, "wr_unmap");
        bus(BASE + 32'h20, 0, 4'hF, 0, "rd_unmap");
        bus(BASE + 32'h14, 1, 4'hF, 32'h0, "wr_id");
        bus(BASE + 32'h14, 0, 4'hF, 0, "rd_id2");
        bus(32'h3000_0000, 1, 4'hF, 32'h0, "outwin_wr");
        bus(32'h3000_0000, 0, 4'hF, 0, "outwin_rd");
        bus(BASE, 0, 4'hF, 0, "rd_after_outwin");

        bus(BASE + 32'h00, 1, 4'hF, 32'h1, "leg_clk");
        bus(BASE + 32'h04, 1, 4'hF, 32'h1, "leg_trap");
        bus(BASE + 32'h08, 1, 4'hF, 32'h1, "leg_src");
        bus(BASE + 32'h00, 0, 4'hF, 0, "leg_rd_clk");
        bus(BASE + 32'h04, 0, 4'hF, 0, "leg_rd_trap");
        bus(BASE + 32'h08, 0, 4'hF, 0, "leg_rd_src");
        chk("leg clk_out", 32'(clk_out), 32'h1);
        chk("leg trap", 32'(trap), 32'h1);
        chk("leg src", 32'(src), 32'h1);

        bus(BASE + 32'h08, 1, 4'hF, 32'h3, "irq_src");
        bus(BASE + 32'h10, 1, 4'hF, 32'h2, "irq_mask");
        pulse(2'b01, "irq0");
        chk("irq0 irq_o", 32'(irq), 32'd0);
        bus(BASE + 32'h0C, 0, 4'hF, 0, "irq0_stat");

        irq_ext[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("irq1 lat2", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq1 lat3", 32'(irq), 32'd1);
        irq_ext[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_stat = m_stat | 2'b10;
        check_outs("irq1");
        bus(BASE + 32'h0C, 0, 4'hF, 0, "irq1_stat");
        bus(BASE + 32'h0C, 1, 4'hF, 32'h2, "w1c_1");
        bus(BASE + 32'h0C, 0, 4'hF, 0, "w1c_1_stat");
        chk("w1c irq_o", 32'(irq), 32'd0);

        irq_ext[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus(BASE + 32'h0C, 1, 4'hF, 32'h2, "race_w1c", 2'b10);
        bus(BASE + 32'h0C, 0, 4'hF, 0, "race_stat");
        chk("race irq_o", 32'(irq), 32'd1);
        bus(BASE + 32'h0C, 1, 4'hF, 32'h2, "held_w1c");
        repeat (4) @(posedge clk);
        #1;
        bus(BASE + 32'h0C, 0, 4'hF, 0, "held_stat");
        chk("held irq_o", 32'(irq), 32'd0);
        irq_ext[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        bus(BASE + 32'h0C, 1, 4'hF, 32'h3, "clr_all");
        bus(BASE + 32'h08, 1, 4'hF, 32'h0, "src_off");
        pulse(2'b11, "gated");
        bus(BASE + 32'h0C, 0, 4'hF, 0, "gated_stat");
        chk("gated irq_o", 32'(irq), 32'd0);

        for (int k = 0; k < 3; k++) begin
            me.rd = 1; me.d = IDV; me.nm = "hold_rd";
            q.push_back(me);
        end
        adr = BASE + 32'h14; we = 0; sel = 4'hF; stb = 1; cyc = 1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold ack c%0d", k), 32'(ack), 32'(k % 2));
        end
        stb = 0; cyc = 0;
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                pulse(2'($urandom_range(1, 3)), "rnd_irq");
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    a = $urandom;
                    if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
                end else begin
                    a = BASE | (32'($urandom_range(0, 15)) << 2);
                end
                d = $urandom;
                bus(a, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), d, "rnd_bus");
            end
        end

        chk("queue empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
